div_unit: RTL and testbench

Multi-cycle integer divider that pairs with the ALU's single-cycle multiply. It produces quotient (LO) and remainder (HI) for signed and unsigned divide. It sits beside the ALU in the EX stage. The hazard unit stalls the pipeline while busy is high.

---
 rtl/div_pkg.sv | 13 +
 rtl/div_step.sv | 29 ++
 rtl/div_unit.sv | 122 ++++++++++++
 tb/tb_div_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants for the multi-cycle divider: FSM encodings, iteration count
// and counter width for the default 32-bit build.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITERS = DIV_WIDTH;
  localparam int DIV_CNT_W = $clog2(DIV_ITERS + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift {rem, quo} left,
// trial-subtract the divisor, keep the difference when it does not borrow.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);

  logic [WIDTH:0] shifted;
  logic           borrow;

  assign shifted = {rem, quo[WIDTH-1]};
  assign borrow  = (shifted < {1'b0, dvs});

  // rem < dvs on entry, so a non-borrowing difference always fits in WIDTH bits
  always_comb begin
    rem_nxt = shifted[WIDTH-1:0];
    quo_nxt = {quo[WIDTH-2:0], 1'b0};
    if (!borrow) begin
      rem_nxt = shifted[WIDTH-1:0] - dvs;
      quo_nxt = {quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned restoring divider (quotient = LO, remainder = HI).
// Define DIV_ZERO_FLAG_EN to add the div_zero output flag.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_ITERS
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             Sign,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             flush,
  output logic             busy,
  output logic             done,
`ifdef DIV_ZERO_FLAG_EN
  output logic             div_zero,
`endif
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic             qneg_q;
  logic             rneg_q;
  logic             dz_q;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic             last_iter;

  function automatic logic [WIDTH-1:0] negate(input logic signed [WIDTH-1:0] v);
    return WIDTH'(-v);
  endfunction

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic                    sgn);
    return (sgn && v[WIDTH-1]) ? negate(v) : v;
  endfunction

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .dvs     (dvs_q),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  assign busy      = (state != IDLE);
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      dz_q      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        // capture operands as magnitudes plus result sign flags
        IDLE: begin
          if (start && !flush) begin
            state  <= CALC;
            cnt    <= '0;
            rem_q  <= '0;
            quo_q  <= magnitude(in1, Sign);
            dvs_q  <= magnitude(in2, Sign);
            qneg_q <= (in1[WIDTH-1] ^ in2[WIDTH-1]) && Sign;
            rneg_q <= in1[WIDTH-1] && Sign;
            dz_q   <= (in2 == '0);
          end
        end
        // one restoring step per cycle for WIDTH cycles
        CALC: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt   <= cnt + CNT_W'(1);
            if (last_iter) state <= FIX;
          end
        end
        // sign fix-up; divide by zero keeps the all-ones quotient in every mode
        FIX: begin
          state <= IDLE;
          if (!flush) begin
            quotient  <= (qneg_q && !dz_q) ? negate(quo_q) : quo_q;
            remainder <= rneg_q ? negate(rem_q) : rem_q;
            done      <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DIV_ZERO_FLAG_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_zero <= 1'b0;
    end else if (state == FIX && !flush) begin
      div_zero <= dz_q;
    end
  end
`endif

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit; build with +define+DIV_ZERO_FLAG_EN
// to also cover the div_zero flag.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        Sign = 1'b0;
  logic [31:0] in1 = '0;
  logic [31:0] in2 = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
`ifdef DIV_ZERO_FLAG_EN
  logic        div_zero;
`endif

  int total = 0;
  int bad   = 0;
  int done_seen = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .Sign      (Sign),
    .in1       (in1),
    .in2       (in2),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
`ifdef DIV_ZERO_FLAG_EN
    .div_zero  (div_zero),
`endif
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_seen++;

  // Present a request; returns #1 after the capturing edge N.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; Sign = s; in1 = a; in2 = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Runs one divide; lat = edges from N to done (-1 on timeout).
  task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic busy_ok);
    issue(s, a, b);
    busy_ok = busy;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        if (busy) busy_ok = 1'b0;
        break;
      end else if (!busy) begin
        busy_ok = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    step(2);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    total++; if (quotient !== 32'h0) begin bad++; $display("FAIL reset_quo got=%h want=0", quotient); end
    total++; if (remainder !== 32'h0) begin bad++; $display("FAIL reset_rem got=%h want=0", remainder); end
    @(negedge clk); reset_n = 1'b1;
    step(1);
  endtask

  task automatic test_unsigned;
    int lat; logic bok;
    do_div(1'b0, 32'd100, 32'd7, lat, bok);
    total++; if (lat !== 33) begin bad++; $display("FAIL u100_7_latency got=%0d want=33", lat); end
    total++; if (bok !== 1'b1) begin bad++; $display("FAIL u100_7_busy got=%b want=1", bok); end
    total++; if (quotient !== 32'd14) begin bad++; $display("FAIL u100_7_quo got=%h want=%h", quotient, 32'd14); end
    total++; if (remainder !== 32'd2) begin bad++; $display("FAIL u100_7_rem got=%h want=%h", remainder, 32'd2); end
    step(1);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL done_one_cycle got=%b want=0", done); end
    total++; if (quotient !== 32'd14) begin bad++; $display("FAIL quo_hold got=%h want=%h", quotient, 32'd14); end
    do_div(1'b0, 32'hFFFF_FFFF, 32'd1, lat, bok);
    total++; if (quotient !== 32'hFFFF_FFFF) begin bad++; $display("FAIL umax_1_quo got=%h want=ffffffff", quotient); end
    total++; if (remainder !== 32'h0) begin bad++; $display("FAIL umax_1_rem got=%h want=0", remainder); end
  endtask

  task automatic test_signed;
    int lat; logic bok;
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, lat, bok);
    total++; if (lat !== 33) begin bad++; $display("FAIL sneg7_2_latency got=%0d want=33", lat); end
    total++; if (quotient !== 32'hFFFF_FFFD) begin bad++; $display("FAIL sneg7_2_quo got=%h want=fffffffd", quotient); end
    total++; if (remainder !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sneg7_2_rem got=%h want=ffffffff", remainder); end
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE, lat, bok);
    total++; if (quotient !== 32'hFFFF_FFFD) begin bad++; $display("FAIL s7_neg2_quo got=%h want=fffffffd", quotient); end
    total++; if (remainder !== 32'd1) begin bad++; $display("FAIL s7_neg2_rem got=%h want=1", remainder); end
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, bok);
    total++; if (quotient !== 32'h8000_0000) begin bad++; $display("FAIL sovf_quo got=%h want=80000000", quotient); end
    total++; if (remainder !== 32'h0) begin bad++; $display("FAIL sovf_rem got=%h want=0", remainder); end
  endtask

  task automatic test_div_zero;
    int lat; logic bok;
    do_div(1'b0, 32'd5, 32'd0, lat, bok);
    total++; if (lat !== 33) begin bad++; $display("FAIL u5_0_latency got=%0d want=33", lat); end
    total++; if (quotient !== 32'hFFFF_FFFF) begin bad++; $display("FAIL u5_0_quo got=%h want=ffffffff", quotient); end
    total++; if (remainder !== 32'd5) begin bad++; $display("FAIL u5_0_rem got=%h want=5", remainder); end
`ifdef DIV_ZERO_FLAG_EN
    total++; if (div_zero !== 1'b1) begin bad++; $display("FAIL u5_0_flag got=%b want=1", div_zero); end
`endif
    do_div(1'b1, 32'hFFFF_FFFB, 32'd0, lat, bok);
    total++; if (quotient !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sneg5_0_quo got=%h want=ffffffff", quotient); end
    total++; if (remainder !== 32'hFFFF_FFFB) begin bad++; $display("FAIL sneg5_0_rem got=%h want=fffffffb", remainder); end
    do_div(1'b0, 32'd30, 32'd4, lat, bok);
    total++; if (quotient !== 32'd7) begin bad++; $display("FAIL u30_4_quo got=%h want=7", quotient); end
    total++; if (remainder !== 32'd2) begin bad++; $display("FAIL u30_4_rem got=%h want=2", remainder); end
`ifdef DIV_ZERO_FLAG_EN
    total++; if (div_zero !== 1'b0) begin bad++; $display("FAIL flag_clear got=%b want=0", div_zero); end
`endif
  endtask

  task automatic test_flush;
    int lat; logic bok; int d0;
    // prior result is 30/4 = 7 r 2
    d0 = done_seen;
    issue(1'b0, 32'd50, 32'd3);
    step(9);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b want=0", busy); end
    total++; if (quotient !== 32'd7) begin bad++; $display("FAIL flush_quo_hold got=%h want=7", quotient); end
    total++; if (remainder !== 32'd2) begin bad++; $display("FAIL flush_rem_hold got=%h want=2", remainder); end
    do_div(1'b0, 32'd9, 32'd4, lat, bok);
    total++; if (lat !== 33) begin bad++; $display("FAIL post_flush_latency got=%0d want=33", lat); end
    total++; if (quotient !== 32'd2) begin bad++; $display("FAIL u9_4_quo got=%h want=2", quotient); end
    total++; if (remainder !== 32'd1) begin bad++; $display("FAIL u9_4_rem got=%h want=1", remainder); end
    total++; if (done_seen - d0 !== 1) begin bad++; $display("FAIL flush_done_count got=%0d want=1", done_seen - d0); end
    // start together with flush is dropped
    @(negedge clk);
    start = 1'b1; flush = 1'b1; Sign = 1'b0; in1 = 32'd8; in2 = 32'd2;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL start_flush_busy got=%b want=0", busy); end
    step(40);
    total++; if (quotient !== 32'd2) begin bad++; $display("FAIL start_flush_quo got=%h want=2", quotient); end
  endtask

  task automatic test_back_to_back;
    int lat; int d0;
    d0 = done_seen;
    lat = -1;
    issue(1'b0, 32'd1000, 32'd10);
    step(4);
    start = 1'b1; in1 = 32'd77; in2 = 32'd5;
    for (int k = 5; k <= 40; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin lat = k; break; end
    end
    total++; if (lat !== 33) begin bad++; $display("FAIL b2b_latency got=%0d want=33", lat); end
    total++; if (quotient !== 32'd100) begin bad++; $display("FAIL b2b_quo got=%h want=%h", quotient, 32'd100); end
    total++; if (remainder !== 32'd0) begin bad++; $display("FAIL b2b_rem got=%h want=0", remainder); end
    step(40);
    total++; if (done_seen - d0 !== 1) begin bad++; $display("FAIL b2b_done_count got=%0d want=1", done_seen - d0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_no_queue got=%b want=0", busy); end
  endtask

  task automatic test_reset_mid;
    int lat; logic bok;
    issue(1'b0, 32'd45, 32'd7);
    step(19);
    #3 reset_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b want=0", done); end
    total++; if (quotient !== 32'h0) begin bad++; $display("FAIL midrst_quo got=%h want=0", quotient); end
    total++; if (remainder !== 32'h0) begin bad++; $display("FAIL midrst_rem got=%h want=0", remainder); end
    @(negedge clk); reset_n = 1'b1;
    do_div(1'b0, 32'd20, 32'd6, lat, bok);
    total++; if (lat !== 33) begin bad++; $display("FAIL u20_6_latency got=%0d want=33", lat); end
    total++; if (bok !== 1'b1) begin bad++; $display("FAIL u20_6_busy got=%b want=1", bok); end
    total++; if (quotient !== 32'd3) begin bad++; $display("FAIL u20_6_quo got=%h want=3", quotient); end
    total++; if (remainder !== 32'd2) begin bad++; $display("FAIL u20_6_rem got=%h want=2", remainder); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
